// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and mod-26 helpers for the Enigma datapath.
package enigma_pkg;

    localparam int LETTER_A    = 65;
    localparam int NUM_LETTERS = 26;
    localparam int TABLE_W     = 208;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [5:0] add26(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 7'd26) s = s - 7'd26;
        return s[5:0];
    endfunction

    // Adds 26 before subtracting so the intermediate never goes negative.
    function automatic logic [5:0] sub26(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + 7'd26 - {1'b0, b};
        if (s >= 7'd26) s = s - 7'd26;
        return s[5:0];
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'(LETTER_A)) && (c <= 8'(LETTER_A + NUM_LETTERS - 1));
    endfunction

endpackage

// File: rtl/rotor_map.sv
// Combinational wiring lookup: forward substitution or inverse search with an offset.
module rotor_map
    import enigma_pkg::*;
(
    input  logic [TABLE_W-1:0] tbl_i,
    input  logic [5:0]         off_i,
    input  logic [7:0]         char_i,
    input  logic               dec_i,
    output logic [7:0]         char_o
);

    logic [7:0] ent [NUM_LETTERS];
    logic [5:0] d;
    logic [5:0] s;
    logic [7:0] fwd_ent;
    logic [5:0] w;
    logic [7:0] t_ch;
    logic [5:0] j;
    logic       hit;

    always_comb begin
        for (int i = 0; i < NUM_LETTERS; i++) begin
            ent[i] = tbl_i[TABLE_W-8-8*i +: 8];
        end
    end

    always_comb begin
        d       = 6'(char_i - 8'(LETTER_A));
        s       = add26(d, off_i);
        fwd_ent = 8'h00;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (s == i[5:0]) fwd_ent = ent[i];
        end
        w = 6'(fwd_ent - 8'(LETTER_A));

        // Scan downward so the lowest matching index is the one kept.
        t_ch = {2'b00, s} + 8'(LETTER_A);
        j    = 6'd0;
        hit  = 1'b0;
        for (int i = NUM_LETTERS - 1; i >= 0; i--) begin
            if (ent[i] == t_ch) begin
                hit = 1'b1;
                j   = i[5:0];
            end
        end

        if (dec_i) begin
            char_o = hit ? ({2'b00, sub26(j, off_i)} + 8'(LETTER_A)) : char_i;
        end else begin
            char_o = {2'b00, sub26(w, off_i)} + 8'(LETTER_A);
        end
    end

endmodule

// File: rtl/enigma_rotor.sv
// Single Enigma rotor stage: FSM, position/notch state and stepping around rotor_map.
// Optional ring setting enabled by defining ENIGMA_ROTOR_RING_EN.
module enigma_rotor
    import enigma_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               set,
    input  logic [TABLE_W-1:0] idx_in,
    input  logic [7:0]         init_pos,
    input  logic [7:0]         notch,
`ifdef ENIGMA_ROTOR_RING_EN
    input  logic [7:0]         ring_in,
`endif
    input  logic               valid,
    input  logic [7:0]         din,
    input  logic               dec,
    input  logic               step_in,
    output logic [7:0]         dout,
    output logic               done,
    output logic               step_out
);

    state_e             state_q, state_d;
    logic [TABLE_W-1:0] tbl_q;
    logic [5:0]         pos_q, pos_d;
    logic [7:0]         notch_q;
    logic [5:0]         ring_q;
    logic [7:0]         din_q, dec_q_unused;
    logic               dec_q, step_q;
    logic [7:0]         res_q;
    logic               carry_q;
    logic [7:0]         dout_q, dout_d;
    logic               done_q, done_d;
    logic               sout_q, sout_d;

    logic               accept;
    logic               load;
    logic               letter;
    logic               do_step;
    logic [5:0]         off;
    logic [7:0]         map_out;
    logic [7:0]         res_d;

    assign dec_q_unused = 8'h00;
    assign load   = (state_q == ST_IDLE) && set;
    assign accept = (state_q == ST_IDLE) && valid && !set;

    assign letter  = is_letter(din_q);
    assign do_step = letter && !dec_q && step_q;
    assign pos_d   = do_step ? add26(pos_q, 6'd1) : pos_q;
    assign off     = sub26(pos_d, ring_q);
    assign res_d   = letter ? map_out : din_q;

    rotor_map u_map (
        .tbl_i  (tbl_q),
        .off_i  (off),
        .char_i (din_q),
        .dec_i  (dec_q),
        .char_o (map_out)
    );

    always_comb begin
        state_d = state_q;
        dout_d  = 8'h00;
        done_d  = 1'b0;
        sout_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                dout_d  = res_q;
                done_d  = 1'b1;
                sout_d  = carry_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tbl_q   <= '0;
            pos_q   <= 6'd0;
            notch_q <= 8'h00;
            ring_q  <= 6'd0;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            sout_q  <= sout_d;
            if (load) begin
                tbl_q   <= idx_in;
                pos_q   <= 6'(init_pos - 8'(LETTER_A));
                notch_q <= notch - 8'(LETTER_A);
`ifdef ENIGMA_ROTOR_RING_EN
                ring_q  <= 6'(ring_in - 8'(LETTER_A));
`else
                ring_q  <= 6'd0;
`endif
            end else if (state_q == ST_CALC) begin
                pos_q <= pos_d;
            end
        end
    end

    // Character datapath; the FSM guarantees these are only consumed when valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            din_q  <= din;
            dec_q  <= dec;
            step_q <= step_in;
        end
        if (state_q == ST_CALC) begin
            res_q   <= res_d;
            carry_q <= do_step && ({2'b00, pos_q} == notch_q);
        end
    end

    assign dout     = dout_q | dec_q_unused;
    assign done     = done_q;
    assign step_out = sout_q;

endmodule

// File: tb/tb_enigma_rotor.sv
// Directed self-checking bench for enigma_rotor using Rotor I wiring.
module tb_enigma_rotor;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         set;
    logic [207:0] idx_in;
    logic [7:0]   init_pos;
    logic [7:0]   notch;
    logic         valid;
    logic [7:0]   din;
    logic         dec;
    logic         step_in;
    logic [7:0]   dout;
    logic         done;
    logic         step_out;

    int checks = 0;
    int errors = 0;

    localparam logic [207:0] ROTOR_I = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

    always #5 clk = ~clk;

    enigma_rotor dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set      (set),
        .idx_in   (idx_in),
        .init_pos (init_pos),
        .notch    (notch),
`ifdef ENIGMA_ROTOR_RING_EN
        .ring_in  (8'd65),
`endif
        .valid    (valid),
        .din      (din),
        .dec      (dec),
        .step_in  (step_in),
        .dout     (dout),
        .done     (done),
        .step_out (step_out)
    );

    task automatic load_rotor(input logic [207:0] t, input logic [7:0] p, input logic [7:0] n);
        @(negedge clk);
        idx_in   = t;
        init_pos = p;
        notch    = n;
        set      = 1'b1;
        @(negedge clk);
        set      = 1'b0;
    endtask

    // Sends one character and waits (bounded) for its done strobe.
    task automatic run_char(input logic [7:0] c, input logic d, input logic s,
                            output logic [7:0] o, output logic so, output int lat);
        @(negedge clk);
        din     = c;
        dec     = d;
        step_in = s;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        lat   = -1;
        o     = 8'h00;
        so    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin
                lat = k;
                o   = dout;
                so  = step_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set = 1'b0; valid = 1'b0; din = 8'h00; dec = 1'b0; step_in = 1'b0;
        idx_in = '0; init_pos = 8'h00; notch = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (step_out !== 1'b0) begin errors++; $display("FAIL reset_step_out: got %b want 0", step_out); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        logic [7:0] o; logic so; int lat;
        load_rotor(ROTOR_I, "A", "Q");
        run_char("A", 1'b0, 1'b1, o, so, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fwd_latency: got %0d want 3", lat); end
        checks++; if (o !== "J") begin errors++; $display("FAIL fwd_dout: got %h want 4a", o); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL fwd_step_out: got %b want 0", so); end
    endtask

    task automatic test_inverse();
        logic [7:0] o; logic so; int lat;
        run_char("J", 1'b1, 1'b1, o, so, lat);
        checks++; if (o !== "A") begin errors++; $display("FAIL inv_dout: got %h want 41", o); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL inv_step_out: got %b want 0", so); end
        run_char("A", 1'b0, 1'b0, o, so, lat);
        checks++; if (o !== "J") begin errors++; $display("FAIL inv_no_step_pos: got %h want 4a", o); end
    endtask

    task automatic test_notch();
        logic [7:0] o; logic so; int lat;
        load_rotor(ROTOR_I, "Q", "Q");
        run_char("A", 1'b0, 1'b1, o, so, lat);
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL notch_carry: got %b want 1", so); end
        checks++; if (o !== "D") begin errors++; $display("FAIL notch_dout: got %h want 44", o); end
        run_char("A", 1'b0, 1'b1, o, so, lat);
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL notch_repeat_carry: got %b want 0", so); end
        checks++; if (o !== "A") begin errors++; $display("FAIL notch_repeat_dout: got %h want 41", o); end
    endtask

    task automatic test_wrap();
        logic [7:0] o; logic so; int lat;
        load_rotor(ROTOR_I, "Z", "Q");
        run_char("A", 1'b0, 1'b1, o, so, lat);
        checks++; if (o !== "E") begin errors++; $display("FAIL wrap_dout: got %h want 45", o); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL wrap_step_out: got %b want 0", so); end
    endtask

    task automatic test_nonletter();
        logic [7:0] o; logic so; int lat;
        run_char(8'h20, 1'b0, 1'b1, o, so, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL nonletter_latency: got %0d want 3", lat); end
        checks++; if (o !== 8'h20) begin errors++; $display("FAIL nonletter_dout: got %h want 20", o); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL nonletter_step_out: got %b want 0", so); end
        run_char("A", 1'b0, 1'b0, o, so, lat);
        checks++; if (o !== "E") begin errors++; $display("FAIL nonletter_no_step: got %h want 45", o); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] o; logic so; int lat; int ndone; logic [7:0] seen;
        @(negedge clk);
        din = "A"; dec = 1'b0; step_in = 1'b1; valid = 1'b1;
        @(negedge clk);
        din = "Z"; init_pos = "M"; valid = 1'b1; set = 1'b1;
        @(negedge clk);
        valid = 1'b0; set = 1'b0;
        ndone = 0; seen = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (done) begin ndone++; seen = dout; end
            @(negedge clk);
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
        checks++; if (seen !== "J") begin errors++; $display("FAIL busy_dout: got %h want 4a", seen); end
        run_char("A", 1'b0, 1'b0, o, so, lat);
        checks++; if (o !== "J") begin errors++; $display("FAIL busy_set_ignored: got %h want 4a", o); end
    endtask

    task automatic test_set_wins();
        logic [7:0] o; logic so; int lat; int ndone;
        @(negedge clk);
        idx_in = ROTOR_I; init_pos = "A"; notch = "Q"; set = 1'b1;
        din = "A"; dec = 1'b0; step_in = 1'b1; valid = 1'b1;
        @(negedge clk);
        set = 1'b0; valid = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL setwins_done_count: got %0d want 0", ndone); end
        run_char("A", 1'b0, 1'b0, o, so, lat);
        checks++; if (o !== "E") begin errors++; $display("FAIL setwins_loaded: got %h want 45", o); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] o; logic so; int lat; int bad;
        @(negedge clk);
        din = "A"; dec = 1'b0; step_in = 1'b1; valid = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        reset_n = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || dout !== 8'h00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", bad); end
        reset_n = 1'b1;
        @(negedge clk);
        run_char("C", 1'b1, 1'b0, o, so, lat);
        checks++; if (o !== "C") begin errors++; $display("FAIL midreset_table_cleared: got %h want 43", o); end
        run_char("A", 1'b0, 1'b1, o, so, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL midreset_latency: got %0d want 3", lat); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL midreset_pos_notch_zero: got %b want 1", so); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_notch();
        test_wrap();
        test_nonletter();
        test_ignore_busy();
        test_set_wins();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
